// File: rtl/ex_ctrl_if.sv
// ex_ctrl_if: decode, downstream-status and execute-stage signals around the Y86 E-stage controller.
interface ex_ctrl_if #(parameter int WORD_W = 32);
  logic              e_stall, e_bubble;
  logic [7:0]        d_icode, d_ifun, d_dstE, d_dstM;
  logic [3:0]        d_stat, m_stat, W_stat;
  logic [WORD_W-1:0] d_valA, d_valB, d_valC, alu_valE;
  logic [7:0]        E_icode, E_ifun, E_dstM, e_dstE;
  logic [3:0]        E_stat;
  logic [WORD_W-1:0] E_valA, alu_a, alu_b;
  logic [1:0]        alu_fun;
  logic              e_cnd, halted;
  logic [2:0]        cc;
  modport slave (
    input  e_stall, e_bubble, d_icode, d_ifun, d_stat, d_valA, d_valB, d_valC,
           d_dstE, d_dstM, m_stat, W_stat, alu_valE,
    output E_icode, E_ifun, E_stat, E_valA, E_dstM, alu_a, alu_b, alu_fun,
           e_dstE, e_cnd, cc, halted
  );
  modport master (
    output e_stall, e_bubble, d_icode, d_ifun, d_stat, d_valA, d_valB, d_valC,
           d_dstE, d_dstM, m_stat, W_stat, alu_valE,
    input  E_icode, E_ifun, E_stat, E_valA, E_dstM, alu_a, alu_b, alu_fun,
           e_dstE, e_cnd, cc, halted
  );
endinterface

// File: rtl/ex_ctrl.sv
// ex_ctrl: Y86 execute-stage controller owning the D->E register, condition codes,
// ALU operand/function selection, branch/cmov condition and the halt latch.
module ex_ctrl #(
  parameter int         WORD_W = 32,
  parameter logic [7:0] RNONE  = 8'h0F
) (
  input logic      clk,
  input logic      rst,
  ex_ctrl_if.slave bus
);
  localparam logic [7:0] I_NOP = 8'h1, I_CMOV = 8'h2, I_IRMOV = 8'h3, I_RMMOV = 8'h4,
                         I_MRMOV = 8'h5, I_OPL = 8'h6, I_JXX = 8'h7, I_CALL = 8'h8,
                         I_RET = 8'h9, I_PUSH = 8'hA, I_POP = 8'hB;
  localparam logic [3:0] S_AOK = 4'd1;
  typedef enum logic {RUN, STOP} state_t;
  state_t            r_state, w_next;
  logic [7:0]        r_icode, r_ifun, r_dstE, r_dstM;
  logic [3:0]        r_stat;
  logic [WORD_W-1:0] r_valA, r_valB, r_valC;
  logic [2:0]        r_cc;
  logic              w_set_cc, w_halted, w_of, w_lt, w_cond, w_a31, w_b31, w_v31;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= RUN;
    else      r_state <= w_next;
  always_comb begin
    w_next   = r_state;
    w_halted = r_state == STOP;
    w_set_cc = 1'b0;
    if (r_state == RUN) begin
      w_next   = bus.W_stat != S_AOK ? STOP : RUN;
      w_set_cc = r_icode == I_OPL && bus.m_stat == S_AOK && bus.W_stat == S_AOK;
    end
  end
  // Bubble outranks stall so a squashed slot is never held.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_icode <= I_NOP;  r_ifun <= '0; r_stat <= S_AOK;
      r_valA  <= '0;     r_valB <= '0; r_valC <= '0;
      r_dstE  <= RNONE;  r_dstM <= RNONE;
    end else if (bus.e_bubble) begin
      r_icode <= I_NOP;  r_ifun <= '0; r_stat <= S_AOK;
      r_valA  <= '0;     r_valB <= '0; r_valC <= '0;
      r_dstE  <= RNONE;  r_dstM <= RNONE;
    end else if (!bus.e_stall) begin
      r_icode <= bus.d_icode; r_ifun <= bus.d_ifun;  r_stat <= bus.d_stat;
      r_valA  <= bus.d_valA;  r_valB <= bus.d_valB;  r_valC <= bus.d_valC;
      r_dstE  <= bus.d_dstE;  r_dstM <= bus.d_dstM;
    end
  assign bus.alu_a = (r_icode == I_OPL || r_icode == I_CMOV)        ? r_valA :
                     (r_icode inside {I_IRMOV, I_RMMOV, I_MRMOV})   ? r_valC :
                     (r_icode inside {I_CALL, I_PUSH})              ? {{(WORD_W-3){1'b1}}, 3'b100} :
                     (r_icode inside {I_RET, I_POP})                ? WORD_W'(4) : '0;
  assign bus.alu_b   = (r_icode inside {I_RMMOV, I_MRMOV, I_OPL, I_CALL, I_PUSH, I_RET, I_POP}) ? r_valB : '0;
  assign bus.alu_fun = r_icode == I_OPL ? r_ifun[1:0] : 2'd0;
  assign w_a31 = bus.alu_a[WORD_W-1];
  assign w_b31 = bus.alu_b[WORD_W-1];
  assign w_v31 = bus.alu_valE[WORD_W-1];
  assign w_of  = bus.alu_fun == 2'd0 ? (w_a31 == w_b31 && w_v31 != w_a31) :
                 bus.alu_fun == 2'd1 ? (w_a31 != w_b31 && w_v31 != w_b31) : 1'b0;
  always_ff @(posedge clk or negedge rst)
    if (!rst)          r_cc <= 3'b100;
    else if (w_set_cc) r_cc <= {bus.alu_valE == '0, w_v31, w_of};
  assign w_lt   = r_cc[1] ^ r_cc[0];
  assign w_cond = r_ifun == 8'd0 ? 1'b1 :
                  r_ifun == 8'd1 ? w_lt | r_cc[2] :
                  r_ifun == 8'd2 ? w_lt :
                  r_ifun == 8'd3 ? r_cc[2] :
                  r_ifun == 8'd4 ? ~r_cc[2] :
                  r_ifun == 8'd5 ? ~w_lt :
                  r_ifun == 8'd6 ? ~w_lt & ~r_cc[2] : 1'b0;
  assign bus.e_cnd   = (r_icode == I_JXX || r_icode == I_CMOV) && w_cond;
  assign bus.e_dstE  = (r_icode == I_CMOV && !w_cond) ? RNONE : r_dstE;
  assign bus.E_icode = r_icode;
  assign bus.E_ifun  = r_ifun;
  assign bus.E_stat  = r_stat;
  assign bus.E_valA  = r_valA;
  assign bus.E_dstM  = r_dstM;
  assign bus.cc      = r_cc;
  assign bus.halted  = w_halted;
endmodule

// File: tb/tb_ex_ctrl.sv
// tb_ex_ctrl: vector table, directed corner sequences and random stimulus for ex_ctrl,
// checked against an instruction-level model of the execute stage.
module tb_ex_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  ex_ctrl_if #(.WORD_W(32)) bus();
  ex_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [7:0]  icode, ifun;
    logic [3:0]  stat;
    logic [31:0] valA, valB, valC;
    logic [7:0]  dstE, dstM;
  } ereg_t;
  typedef struct {
    logic [7:0]  icode, ifun;
    logic [31:0] a_exp, b_exp;
    logic [1:0]  fun_exp;
  } vec_t;

  ereg_t      me;
  logic [2:0] mcc;
  logic       mhalt;
  int         errors = 0, checks = 0;
  vec_t       vt[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ereg_t bubble_e();
    ereg_t e;
    e.icode = 8'd1; e.ifun = 8'd0; e.stat = 4'd1;
    e.valA = 0; e.valB = 0; e.valC = 0;
    e.dstE = 8'h0F; e.dstM = 8'h0F;
    return e;
  endfunction

  function automatic logic [31:0] ea(ereg_t e);
    case (e.icode)
      8'd6, 8'd2:        return e.valA;
      8'd3, 8'd4, 8'd5:  return e.valC;
      8'd8, 8'd10:       return 32'hFFFF_FFFC;
      8'd9, 8'd11:       return 32'd4;
      default:           return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] eb(ereg_t e);
    case (e.icode)
      8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd11: return e.valB;
      default:                                    return 32'd0;
    endcase
  endfunction

  function automatic logic [1:0] efun(ereg_t e);
    return e.icode == 8'd6 ? e.ifun[1:0] : 2'd0;
  endfunction

  function automatic logic [31:0] alu_res(ereg_t e);
    logic [31:0] a, b;
    a = ea(e); b = eb(e);
    case (efun(e))
      2'd0:    return b + a;
      2'd1:    return b - a;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Overflow taken from the true signed result, not from sign-bit patterns.
  function automatic logic [2:0] new_cc(ereg_t e, logic [31:0] r);
    longint sa, sb, s;
    logic of;
    sa = longint'($signed(ea(e)));
    sb = longint'($signed(eb(e)));
    of = 1'b0;
    if (efun(e) == 2'd0) begin s = sb + sa; of = s > 64'sd2147483647 || s < -64'sd2147483648; end
    if (efun(e) == 2'd1) begin s = sb - sa; of = s > 64'sd2147483647 || s < -64'sd2147483648; end
    return {r == 32'd0, r[31], of};
  endfunction

  function automatic logic cond(logic [2:0] c, logic [7:0] f);
    logic zf, lt;
    zf = c[2]; lt = c[1] ^ c[0];
    case (f)
      8'd0: return 1'b1;
      8'd1: return lt | zf;
      8'd2: return lt;
      8'd3: return zf;
      8'd4: return !zf;
      8'd5: return !lt;
      8'd6: return !lt && !zf;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic exp_cnd(ereg_t e, logic [2:0] c);
    return (e.icode == 8'd7 || e.icode == 8'd2) ? cond(c, e.ifun) : 1'b0;
  endfunction

  function automatic logic [7:0] exp_dste(ereg_t e, logic [2:0] c);
    return (e.icode == 8'd2 && !cond(c, e.ifun)) ? 8'h0F : e.dstE;
  endfunction

  task automatic model_reset();
    me = bubble_e(); mcc = 3'b100; mhalt = 1'b0;
    bus.alu_valE = alu_res(me);
  endtask

  task automatic model_edge();
    if (me.icode == 8'd6 && !mhalt && bus.m_stat == 4'd1 && bus.W_stat == 4'd1)
      mcc = new_cc(me, bus.alu_valE);
    if (bus.W_stat != 4'd1) mhalt = 1'b1;
    if (bus.e_bubble) me = bubble_e();
    else if (!bus.e_stall) begin
      me.icode = bus.d_icode; me.ifun = bus.d_ifun; me.stat = bus.d_stat;
      me.valA = bus.d_valA;   me.valB = bus.d_valB; me.valC = bus.d_valC;
      me.dstE = bus.d_dstE;   me.dstM = bus.d_dstM;
    end
  endtask

  task automatic check_all();
    chk("E_icode", bus.E_icode, me.icode);
    chk("E_ifun",  bus.E_ifun,  me.ifun);
    chk("E_stat",  bus.E_stat,  me.stat);
    chk("E_valA",  bus.E_valA,  me.valA);
    chk("E_dstM",  bus.E_dstM,  me.dstM);
    chk("alu_a",   bus.alu_a,   ea(me));
    chk("alu_b",   bus.alu_b,   eb(me));
    chk("alu_fun", bus.alu_fun, efun(me));
    chk("e_cnd",   bus.e_cnd,   exp_cnd(me, mcc));
    chk("e_dstE",  bus.e_dstE,  exp_dste(me, mcc));
    chk("cc",      bus.cc,      mcc);
    chk("halted",  bus.halted,  mhalt);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    bus.alu_valE = alu_res(me);
    check_all();
  endtask

  task automatic ld(input logic [7:0] ic, input logic [7:0] fn, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] c, input logic [7:0] de);
    bus.d_icode = ic; bus.d_ifun = fn; bus.d_stat = 4'd1;
    bus.d_valA = a;   bus.d_valB = b;  bus.d_valC = c;
    bus.d_dstE = de;  bus.d_dstM = 8'h0F;
  endtask

  initial begin
    vt[0]  = '{8'd6,  8'd2, 32'd11,         32'd22, 2'd2};
    vt[1]  = '{8'd2,  8'd0, 32'd11,         32'd0,  2'd0};
    vt[2]  = '{8'd3,  8'd0, 32'd33,         32'd0,  2'd0};
    vt[3]  = '{8'd4,  8'd0, 32'd33,         32'd22, 2'd0};
    vt[4]  = '{8'd5,  8'd0, 32'd33,         32'd22, 2'd0};
    vt[5]  = '{8'd8,  8'd0, 32'hFFFF_FFFC,  32'd22, 2'd0};
    vt[6]  = '{8'd10, 8'd0, 32'hFFFF_FFFC,  32'd22, 2'd0};
    vt[7]  = '{8'd9,  8'd0, 32'd4,          32'd22, 2'd0};
    vt[8]  = '{8'd11, 8'd0, 32'd4,          32'd22, 2'd0};
    vt[9]  = '{8'd7,  8'd3, 32'd0,          32'd0,  2'd0};
    vt[10] = '{8'd0,  8'd0, 32'd0,          32'd0,  2'd0};
    vt[11] = '{8'd1,  8'd0, 32'd0,          32'd0,  2'd0};
    vt[12] = '{8'd6,  8'd3, 32'd11,         32'd22, 2'd3};

    bus.e_stall = 1'b0; bus.e_bubble = 1'b0;
    bus.m_stat = 4'd1;  bus.W_stat = 4'd1;
    ld(8'd1, 8'd0, 0, 0, 0, 8'h0F);
    model_reset();
    #12;
    check_all();
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_icode", bus.E_icode, 32'd1);
    chk("rst_cc",    bus.cc,      32'b100);
    chk("rst_dstE",  bus.e_dstE,  32'h0F);
    chk("rst_halt",  bus.halted,  32'd0);
    chk("rst_fun",   bus.alu_fun, 32'd0);

    ld(8'd6, 8'd1, 32'd5, 32'd5, 0, 8'd3); tick();
    chk("sub_fun", bus.alu_fun, 32'd1);
    ld(8'd7, 8'd3, 0, 0, 0, 8'h0F); tick();
    chk("sub_cc", bus.cc, 32'b100);
    chk("je_cnd", bus.e_cnd, 32'd1);
    ld(8'd7, 8'd4, 0, 0, 0, 8'h0F); tick();
    chk("jne_cnd", bus.e_cnd, 32'd0);

    ld(8'd6, 8'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 8'd3); tick();
    ld(8'd7, 8'd2, 0, 0, 0, 8'h0F); tick();
    chk("ovf_cc", bus.cc, 32'b011);
    chk("jl_cnd", bus.e_cnd, 32'd0);
    ld(8'd7, 8'd6, 0, 0, 0, 8'h0F); tick();
    chk("jg_cnd", bus.e_cnd, 32'd1);

    ld(8'd6, 8'd0, 32'd1, 32'd1, 0, 8'd3); tick();
    ld(8'd2, 8'd1, 32'hAA, 32'hBB, 32'hCC, 8'd3); tick();
    chk("cmov_cc0",   bus.cc,     32'b000);
    chk("cmov_squash", bus.e_dstE, 32'h0F);
    chk("cmov_a",     bus.alu_a,  32'hAA);
    chk("cmov_b",     bus.alu_b,  32'd0);
    ld(8'd6, 8'd1, 32'd5, 32'd5, 0, 8'd3); tick();
    ld(8'd2, 8'd1, 32'hAA, 32'hBB, 32'hCC, 8'd3); tick();
    chk("cmov_cc1",  bus.cc,     32'b100);
    chk("cmov_keep", bus.e_dstE, 32'd3);

    for (int i = 0; i < 13; i++) begin
      ld(vt[i].icode, vt[i].ifun, 32'd11, 32'd22, 32'd33, 8'd5); tick();
      chk("vec_a",   bus.alu_a,   vt[i].a_exp);
      chk("vec_b",   bus.alu_b,   vt[i].b_exp);
      chk("vec_fun", bus.alu_fun, vt[i].fun_exp);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = $urandom();
      ld(8'($urandom_range(0, 12)), 8'($urandom_range(0, 7)), ra,
         ($urandom_range(0, 3) == 0) ? ra : $urandom(), $urandom(), 8'($urandom_range(0, 15)));
      bus.d_stat   = 4'($urandom_range(1, 4));
      bus.d_dstM   = 8'($urandom_range(0, 15));
      bus.e_stall  = $urandom_range(0, 7) == 0;
      bus.e_bubble = $urandom_range(0, 9) == 0;
      bus.m_stat   = ($urandom_range(0, 5) == 0) ? 4'd3 : 4'd1;
      tick();
    end
    bus.e_stall = 1'b0; bus.e_bubble = 1'b0; bus.m_stat = 4'd1;

    ld(8'd3, 8'd0, 0, 0, 32'h55, 8'd2); tick();
    ld(8'd6, 8'd0, 32'd1, 32'd1, 0, 8'd3); bus.e_stall = 1'b1; tick();
    chk("stall_hold", bus.E_icode, 32'd3);
    bus.e_bubble = 1'b1; tick();
    chk("bubble_prio", bus.E_icode, 32'd1);
    bus.e_stall = 1'b0; bus.e_bubble = 1'b0;
    ld(8'd10, 8'd0, 0, 32'h100, 0, 8'd4); tick();
    chk("push_a",   bus.alu_a,   32'hFFFF_FFFC);
    chk("push_b",   bus.alu_b,   32'h100);
    chk("push_fun", bus.alu_fun, 32'd0);

    ld(8'd6, 8'd1, 32'd5, 32'd5, 0, 8'd3); tick();
    ld(8'd1, 8'd0, 0, 0, 0, 8'h0F); tick();
    ld(8'd6, 8'd0, 32'd1, 32'd1, 0, 8'd3); tick();
    bus.m_stat = 4'd3; ld(8'd1, 8'd0, 0, 0, 0, 8'h0F); tick();
    chk("adr_cc", bus.cc, 32'b100);
    bus.m_stat = 4'd1; bus.W_stat = 4'd2; tick();
    chk("halt_set", bus.halted, 32'd1);
    bus.W_stat = 4'd1; ld(8'd6, 8'd0, 32'd1, 32'd1, 0, 8'd3); tick();
    ld(8'd1, 8'd0, 0, 0, 0, 8'h0F); tick();
    chk("stop_cc",   bus.cc,     32'b100);
    chk("stop_halt", bus.halted, 32'd1);

    ld(8'd6, 8'd0, 32'd1, 32'd1, 0, 8'd3); tick();
    #3 rst = 1'b0;
    #1 model_reset();
    check_all();
    chk("arst_halt", bus.halted, 32'd0);
    #2 rst = 1'b1;
    ld(8'd6, 8'd0, 32'd1, 32'd1, 0, 8'd3); tick();
    ld(8'd1, 8'd0, 0, 0, 0, 8'h0F); tick();
    chk("rerun_cc", bus.cc, 32'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
